// File: rtl/oam_dma_engine_if.sv
// Bus bundle for the OAM DMA engine: CPU register port, source read port,
// OAM write port and the M-cycle tick.
interface oam_dma_engine_if;
  logic        tick;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write_en;
  logic        cpu_read_en;
  logic [7:0]  cpu_rdata;
  logic [15:0] dma_addr;
  logic        dma_read_en;
  logic [7:0]  dma_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_write_en;
  logic        dma_active;

  // Engine side
  modport slave (
    input  tick, cpu_addr, cpu_wdata, cpu_write_en, cpu_read_en, dma_rdata,
    output cpu_rdata, dma_addr, dma_read_en, oam_addr, oam_wdata,
    oam_write_en, dma_active
  );

  // System / environment side
  modport master (
    output tick, cpu_addr, cpu_wdata, cpu_write_en, cpu_read_en, dma_rdata,
    input  cpu_rdata, dma_addr, dma_read_en, oam_addr, oam_wdata,
    oam_write_en, dma_active
  );
endinterface

// File: rtl/oam_dma_engine.sv
// DMG OAM DMA controller: owns the FF46 source/trigger register and copies
// XFER_LEN bytes from page {src_hi,00} into OAM, one byte per M-cycle tick.
//
// state | meaning
// IDLE  | no transfer, buses released
// DELAY | trigger seen, waiting one M-cycle before moving bytes
// XFER  | reading source byte idx and writing it to OAM on each tick
module oam_dma_engine #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter int          XFER_LEN     = 160,
  parameter logic [7:0]  MIRROR_BASE  = 8'hE0
) (
  input  logic            clk,
  input  logic            reset,
  oam_dma_engine_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DELAY, XFER} state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t      state;
  logic [7:0]  src_hi;
  logic [7:0]  idx;
  logic [7:0]  eff_hi;
  logic [15:0] dma_addr_q;
  logic [7:0]  oam_addr_q;
  logic        active_q;
  logic        read_en_q;
  logic        reg_sel;
  logic        trigger;

  assign reg_sel = (bus.cpu_addr == DMA_REG_ADDR);
  assign trigger = bus.cpu_write_en && reg_sel;

  // Echo RAM (E000-FDFF) aliases work RAM 0x2000 lower
  assign eff_hi = (src_hi >= MIRROR_BASE) ? (src_hi - 8'h20) : src_hi;

  assign bus.cpu_rdata    = (bus.cpu_read_en && reg_sel) ? src_hi : 8'hFF;
  // The write strobe follows the tick directly so a byte is committed in the
  // same clk the source data is valid; reset clears state and kills it at once.
  assign bus.oam_write_en = (state == XFER) && bus.tick;
  assign bus.oam_wdata    = bus.dma_rdata;
  assign bus.dma_addr     = dma_addr_q;
  assign bus.oam_addr     = oam_addr_q;
  assign bus.dma_active   = active_q;
  assign bus.dma_read_en  = read_en_q;

  // Transfer FSM with registered bus outputs; a trigger write always wins and
  // restarts from DELAY, even when it lands on the final byte's tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      src_hi     <= 8'hFF;
      idx        <= 8'd0;
      dma_addr_q <= 16'h0000;
      oam_addr_q <= 8'd0;
      active_q   <= 1'b0;
      read_en_q  <= 1'b0;
    end else if (trigger) begin
      src_hi    <= bus.cpu_wdata;
      state     <= DELAY;
      idx       <= 8'd0;
      active_q  <= 1'b0;
      read_en_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        DELAY: begin
          if (bus.tick) begin
            state      <= XFER;
            idx        <= 8'd0;
            dma_addr_q <= {eff_hi, 8'h00};
            oam_addr_q <= 8'd0;
            active_q   <= 1'b1;
            read_en_q  <= 1'b1;
          end
        end
        XFER: begin
          if (bus.tick) begin
            if (idx == LAST_IDX) begin
              state     <= IDLE;
              active_q  <= 1'b0;
              read_en_q <= 1'b0;
            end else begin
              idx        <= idx + 8'd1;
              dma_addr_q <= {eff_hi, idx + 8'd1};
              oam_addr_q <= idx + 8'd1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          active_q  <= 1'b0;
          read_en_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Self-checking bench for oam_dma_engine: vector table of source pages plus
// restart, final-byte restart and mid-transfer reset sequences. Every OAM
// write is checked against a scoreboard of expected {dma_addr, oam_addr, data}.
module tb_oam_dma_engine;

  logic clk;
  logic reset;
  oam_dma_engine_if bus();

  oam_dma_engine dut (.clk(clk), .reset(reset), .bus(bus));

  // Source bus model
  assign bus.dma_rdata = bus.dma_addr[7:0] ^ bus.dma_addr[15:8] ^ 8'h5A;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  o;
    logic [7:0]  d;
  } exp_t;

  typedef struct {
    logic [7:0] src;
    logic [7:0] exp_hi;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];

  int passed = 0;
  int total  = 0;
  int tcnt   = 0;
  int wr_count, active_ticks;
  int ticks_since, idle_since, first_ws, first_idle;
  bit first_seen;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else passed++;
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s timed out", name);
  endtask

  task automatic push(input logic [7:0] hi, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.a = {hi, 8'(i)};
      e.o = 8'(i);
      e.d = 8'(i) ^ hi ^ 8'h5A;
      sb.push_back(e);
    end
  endtask

  // M-cycle tick: one clk in four
  initial begin
    bus.tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tick = (tcnt % 4 == 0);
      tcnt++;
    end
  end

  // Monitor: scoreboard compare and tick bookkeeping, sampled mid-cycle
  always @(negedge clk) begin
    automatic bit trig_now = bus.cpu_write_en && (bus.cpu_addr == 16'hFF46) && !reset;
    if (bus.tick && bus.dma_active) active_ticks++;
    if (!trig_now && bus.tick) begin
      ticks_since++;
      if (!bus.dma_active) idle_since++;
    end
    if (bus.oam_write_en) begin
      wr_count++;
      if (!first_seen) begin
        first_seen = 1;
        first_ws   = ticks_since;
        first_idle = idle_since;
      end
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_write actual=oam_addr %h required=no write", bus.oam_addr);
      end else begin
        automatic exp_t e = sb.pop_front();
        chk("oam_write", {7'd0, bus.dma_read_en, bus.dma_addr, bus.oam_addr, bus.oam_wdata},
            {7'd0, 1'b1, e.a, e.o, e.d});
      end
    end
    if (trig_now) begin
      ticks_since = 0;
      idle_since  = 0;
      first_seen  = 0;
    end
  end

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    @(posedge clk);
    #2;
    bus.cpu_addr = addr; bus.cpu_wdata = data; bus.cpu_write_en = 1'b1;
    @(posedge clk);
    #2;
    bus.cpu_write_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] addr, output logic [7:0] data);
    @(posedge clk);
    #2;
    bus.cpu_addr = addr; bus.cpu_read_en = 1'b1;
    #1;
    data = bus.cpu_rdata;
    bus.cpu_read_en = 1'b0;
  endtask

  // Wait until idx equals target and that byte has not been written yet
  task automatic wait_idx(input logic [7:0] target);
    int n = 0;
    while (!(bus.dma_active && bus.oam_addr == target && !bus.tick) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("wait_idx");
  endtask

  // Return at the drive point of the next clk that carries a tick
  task automatic wait_tick_cycle();
    int n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!bus.tick && n < 10);
    if (!bus.tick) fail_now("wait_tick");
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || bus.dma_active) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("wait_done");
    repeat (4) @(negedge clk);
  endtask

  task automatic clear_counts();
    wr_count = 0;
    active_ticks = 0;
  endtask

  logic [7:0] rd;

  initial begin
    vecs[0] = '{src: 8'h00, exp_hi: 8'h00};
    vecs[1] = '{src: 8'hC1, exp_hi: 8'hC1};
    vecs[2] = '{src: 8'hFE, exp_hi: 8'hDE};
    vecs[3] = '{src: 8'hDF, exp_hi: 8'hDF};
    vecs[4] = '{src: 8'hE0, exp_hi: 8'hC0};
    vecs[5] = '{src: 8'h7F, exp_hi: 8'h7F};

    reset = 1'b1;
    bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h00;
    bus.cpu_write_en = 1'b0; bus.cpu_read_en = 1'b0;
    clear_counts();
    ticks_since = 0; idle_since = 0; first_ws = 0; first_idle = 0; first_seen = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_active", {39'd0, bus.dma_active}, 40'd0);
    chk("rst_read_en", {39'd0, bus.dma_read_en}, 40'd0);
    chk("rst_dma_addr", {24'd0, bus.dma_addr}, 40'd0);
    chk("rst_oam_addr", {32'd0, bus.oam_addr}, 40'd0);
    repeat (4) begin
      @(posedge clk);
      #2;
      chk("rst_wr_en", {39'd0, bus.oam_write_en}, 40'd0);
    end
    bus.cpu_addr = 16'hFF46; bus.cpu_read_en = 1'b1;
    #1;
    chk("rst_rdata", {32'd0, bus.cpu_rdata}, 40'hFF);
    bus.cpu_read_en = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (8) @(posedge clk);

    // Table-driven full transfers
    for (int v = 0; v < 6; v++) begin
      clear_counts();
      push(vecs[v].exp_hi, 160);
      cpu_write(16'hFF46, vecs[v].src);
      repeat (200) @(posedge clk);
      cpu_read(16'hFF46, rd);
      chk("rd_mid", {32'd0, rd}, {32'd0, vecs[v].src});
      wait_done();
      chk("wr_count", 40'(wr_count), 40'd160);
      chk("active_ticks", 40'(active_ticks), 40'd160);
      chk("first_write_tick", 40'(first_ws), 40'd2);
      cpu_read(16'hFF46, rd);
      chk("rd_after", {32'd0, rd}, {32'd0, vecs[v].src});
    end

    cpu_read(16'hFF47, rd);
    chk("rd_other_addr", {32'd0, rd}, 40'hFF);

    // Restart at idx 50 on a tick
    clear_counts();
    push(8'h00, 51);
    cpu_write(16'hFF46, 8'h00);
    wait_idx(8'd50);
    push(8'h80, 160);
    wait_tick_cycle();
    bus.cpu_addr = 16'hFF46; bus.cpu_wdata = 8'h80; bus.cpu_write_en = 1'b1;
    @(posedge clk);
    #2;
    bus.cpu_write_en = 1'b0;
    wait_done();
    chk("restart_wr_count", 40'(wr_count), 40'd211);
    chk("restart_first_tick", 40'(first_ws), 40'd2);
    chk("restart_idle_ticks", 40'(first_idle), 40'd1);

    // Trigger coincident with the final byte
    clear_counts();
    push(8'h00, 160);
    cpu_write(16'hFF46, 8'h00);
    wait_idx(8'd159);
    push(8'h40, 160);
    wait_tick_cycle();
    bus.cpu_addr = 16'hFF46; bus.cpu_wdata = 8'h40; bus.cpu_write_en = 1'b1;
    @(posedge clk);
    #2;
    bus.cpu_write_en = 1'b0;
    wait_done();
    chk("final_wr_count", 40'(wr_count), 40'd320);
    chk("final_first_tick", 40'(first_ws), 40'd2);
    chk("final_idle_ticks", 40'(first_idle), 40'd1);
    chk("final_active_ticks", 40'(active_ticks), 40'd320);

    // Reset at idx 100
    clear_counts();
    push(8'h00, 100);
    cpu_write(16'hFF46, 8'h00);
    wait_idx(8'd100);
    wait_tick_cycle();
    reset = 1'b1;
    #1;
    chk("abort_wr_en", {39'd0, bus.oam_write_en}, 40'd0);
    chk("abort_active", {39'd0, bus.dma_active}, 40'd0);
    chk("abort_read_en", {39'd0, bus.dma_read_en}, 40'd0);
    bus.cpu_addr = 16'hFF46; bus.cpu_read_en = 1'b1;
    #1;
    chk("abort_rdata", {32'd0, bus.cpu_rdata}, 40'hFF);
    bus.cpu_read_en = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    chk("abort_wr_count", 40'(wr_count), 40'd100);
    chk("abort_sb_empty", 40'(sb.size()), 40'd0);
    chk("abort_idle", {39'd0, bus.dma_active}, 40'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/oam_dma_engine.md
Name: oam_dma_engine

Overview:
- DMG OAM DMA controller. Owns register FF46 on the CPU peripheral bus.
- Acts as a second bus master that reads 160 bytes from a source page. The source is normally cartridge ROM at 0000-7FFF (through the boot-ROM/cartridge decode) or work RAM.
- Writes those bytes into OAM FE00-FE9F, one byte per M-cycle.
- Sits directly downstream of the cartridge/RAM read path and upstream of the OAM/PPU write port.

Parameters:
- DMA_REG_ADDR, 16'hFF46, CPU address of the DMA source/trigger register.
- XFER_LEN, 160, number of bytes per transfer. Must be ≤ 256.
- MIRROR_BASE, 8'hE0, source high bytes ≥ this value have 8'h20 subtracted (echo RAM mapping).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  M-cycle enable, high for one clk per M-cycle.
- cpu_addr  in  16  CPU bus address.
- cpu_wdata  in  8  CPU write data.
- cpu_write_en  in  1  CPU write strobe.
- cpu_read_en  in  1  CPU read strobe.
- cpu_rdata  out  8  register read data. 8'hFF when not selected.
- dma_addr  out  16  source address driven to the read bus.
- dma_read_en  out  1  source read strobe.
- dma_rdata  in  8  source read data. Combinational, valid in the same clk.
- oam_addr  out  8  OAM byte index 0..159.
- oam_wdata  out  8  OAM write data.
- oam_write_en  out  1  OAM write strobe.
- dma_active  out  1  high while bytes are moving; the CPU bus is locked out of non-HRAM space.

Behaviour:
- Reset (async, on reset high):
  - state=IDLE, src_hi=8'hFF, idx=0.
  - dma_active=0, dma_read_en=0, oam_write_en=0, dma_addr=16'h0000, oam_addr=0.
- Register access:
  - A CPU write to DMA_REG_ADDR, sampled on any clk edge (tick not required), latches src_hi=cpu_wdata and triggers a transfer.
  - A CPU read of DMA_REG_ADDR returns src_hi, combinationally.
  - Other addresses read 8'hFF.
- Effective source high byte: eff_hi = (src_hi ≥ MIRROR_BASE) ? src_hi − 8'h20 : src_hi.
- States:
  - IDLE → DELAY on a trigger write.
  - DELAY → XFER on the first tick after entry; idx=0. This gives a 1 M-cycle startup delay, and dma_active stays 0 during DELAY.
  - XFER: dma_active=1, dma_read_en=1, dma_addr={eff_hi, idx}, oam_addr=idx.
- XFER byte transfer (combinational in a tick cycle):
  - oam_write_en = tick.
  - oam_wdata = dma_rdata.
  - At the clock edge, idx increments.
  - When a tick occurs with idx==XFER_LEN−1, the last byte is written and the state goes XFER → IDLE.
- Latency: a trigger to last OAM write takes exactly XFER_LEN+1 ticks. dma_active is high for exactly XFER_LEN ticks.
- Restart: a trigger write during DELAY or XFER reloads src_hi, sets idx=0 and enters DELAY.
- Trigger and tick in the same clk during XFER:
  - The current byte's OAM write still occurs in that cycle.
  - The restart takes effect at the edge: next state DELAY, idx=0.
- Trigger on the same edge as the final byte: the final byte is written, then the state is DELAY (not IDLE).
- Outside XFER: dma_read_en=0 and oam_write_en=0. dma_addr and oam_addr hold their last value (don't-care).
- idx never exceeds XFER_LEN−1. There is no wrap within a page.
- Reset mid-transfer aborts immediately. No further OAM writes occur; src_hi returns to 8'hFF.
- Outputs other than cpu_rdata, oam_write_en and oam_wdata are registered, or decoded from registered state only.

Test Plan:
- Write 8'h00 to FF46, tick every 4 clk, bus model returns addr[7:0]^8'h5A:
  - OAM receives 160 writes, oam_addr 0..159, data idx^8'h5A.
  - First write on the 2nd tick after the trigger.
  - dma_active high for exactly 160 ticks.
- Write 8'hC1:
  - dma_addr steps C100..C19F.
  - A CPU read of FF46 returns 8'hC1 during and after the transfer.
- Write 8'hFE:
  - dma_addr steps DE00..DE9F (mirror subtraction).
  - Write 8'hDF: steps DF00..DF9F, no subtraction.
- Start with 8'h00; at idx=50 (coincident with a tick), write 8'h80:
  - Byte 50 from 0x0032 is written.
  - One DELAY tick with no OAM writes follows.
  - Then 160 writes from 8000..809F.
- Assert reset at idx=100:
  - oam_write_en drops in the same cycle.
  - state IDLE, dma_active=0, FF46 reads 8'hFF.
  - No writes until a new trigger.
- Trigger write on the same edge as the idx=159 tick:
  - Byte 159 is written.
  - The next transfer starts after one DELAY tick.
  - dma_active is low for exactly that one tick.
